// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 data-memory path: access sizes, AHB transfer
// types, exception causes and the controller state enum.
package msrv32_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS      = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Size 11 has no legal alignment, so it is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = (addr != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SIZE_BYTE: r = {4{d[7:0]}};
            SIZE_HALF: r = {2{d[15:0]}};
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Selects the addressed byte/half lane of a bus word and sign- or zero-extends
// it into a 32-bit load result; words pass straight through.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'b00:   byte_sel = data[7:0];
            2'b01:   byte_sel = data[15:8];
            2'b10:   byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = addr[1] ? data[31:16] : data[15:0];

        case (size)
            SIZE_BYTE: result = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory transaction controller: runs one load/store as a single AHB-lite
// transfer with wait-state timeout and misalignment/bus-error exceptions.
module msrv32_dmem_ctrl
    import msrv32_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_unsigned_in,
    output logic        rsp_valid_out,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_err_out,
    output logic [1:0]  rsp_cause_out,
    output logic        busy_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        uns_q, uns_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  rsp_cause_q, rsp_cause_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        busy_q, busy_d;
    logic        req_ready_q, req_ready_d;

    logic [1:0]  resp_cause;
    logic [31:0] resp_rdata;
    logic [31:0] load_result;
    logic [7:0]  wait_inc;
    logic        bus_active;

    msrv32_load_align u_align (
        .data          (hrdata_in),
        .addr          (addr_q[1:0]),
        .size          (size_q),
        .load_unsigned (uns_q),
        .result        (load_result)
    );

    assign wait_inc = wait_cnt_q + 8'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            uns_q       <= 1'b0;
            wait_cnt_q  <= '0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            write_q     <= write_d;
            uns_q       <= uns_d;
            wait_cnt_q  <= wait_cnt_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cause_q <= rsp_cause_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        write_d    = write_q;
        uns_d      = uns_q;
        wait_cnt_d = wait_cnt_q;
        resp_cause = CAUSE_NONE;
        resp_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_in && req_ready_q) begin
                    if (is_misaligned(req_size_in, req_addr_in[1:0])) begin
                        state_d    = ST_RESP;
                        resp_cause = CAUSE_MISALIGN;
                    end else begin
                        state_d = ST_ADDR;
                        addr_d  = req_addr_in;
                        wdata_d = req_wdata_in;
                        size_d  = req_size_in;
                        write_d = req_write_in;
                        uns_d   = req_unsigned_in;
                    end
                end
            end
            ST_ADDR: begin
                if (hready_in) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // A ready on the limit cycle is checked first so completion beats timeout.
                if (hready_in) begin
                    state_d = ST_RESP;
                    if (hresp_in) begin
                        resp_cause = CAUSE_BUS;
                    end else begin
                        resp_rdata = write_q ? 32'd0 : load_result;
                    end
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT_C) begin
                        state_d    = ST_RESP;
                        resp_cause = CAUSE_TIMEOUT;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Outputs are computed from the next state so they appear registered in that state.
    always_comb begin
        bus_active  = (state_d == ST_ADDR) || (state_d == ST_DATA);
        htrans_d    = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        haddr_d     = bus_active ? addr_d : 32'd0;
        hwrite_d    = bus_active ? write_d : 1'b0;
        hsize_d     = bus_active ? {1'b0, size_d} : 3'd0;
        hwdata_d    = (state_d == ST_DATA) ? lane_replicate(size_d, wdata_d) : 32'd0;
        rsp_valid_d = (state_d == ST_RESP);
        rsp_cause_d = rsp_valid_d ? resp_cause : CAUSE_NONE;
        rsp_err_d   = rsp_valid_d && (resp_cause != CAUSE_NONE);
        rsp_rdata_d = rsp_valid_d ? resp_rdata : 32'd0;
        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready_out = req_ready_q;
    assign rsp_valid_out = rsp_valid_q;
    assign rsp_rdata_out = rsp_rdata_q;
    assign rsp_err_out   = rsp_err_q;
    assign rsp_cause_out = rsp_cause_q;
    assign busy_out      = busy_q;
    assign haddr_out     = haddr_q;
    assign htrans_out    = htrans_q;
    assign hwrite_out    = hwrite_q;
    assign hsize_out     = hsize_q;
    assign hwdata_out    = hwdata_q;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Directed bench for msrv32_dmem_ctrl: expected responses are queued when a
// request is driven and checked when rsp_valid_out pulses.
module tb_msrv32_dmem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic [1:0]  req_size_in;
    logic        req_unsigned_in;
    logic        rsp_valid_out;
    logic [31:0] rsp_rdata_out;
    logic        rsp_err_out;
    logic [1:0]  rsp_cause_out;
    logic        busy_out;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic [31:0] hrdata_in;
    logic        hready_in;
    logic        hresp_in;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk_in = ~clk_in;

    msrv32_dmem_ctrl #(.WAIT_LIMIT(16)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_write_in    (req_write_in),
        .req_addr_in     (req_addr_in),
        .req_wdata_in    (req_wdata_in),
        .req_size_in     (req_size_in),
        .req_unsigned_in (req_unsigned_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_rdata_out   (rsp_rdata_out),
        .rsp_err_out     (rsp_err_out),
        .rsp_cause_out   (rsp_cause_out),
        .busy_out        (busy_out),
        .haddr_out       (haddr_out),
        .htrans_out      (htrans_out),
        .hwrite_out      (hwrite_out),
        .hsize_out       (hsize_out),
        .hwdata_out      (hwdata_out),
        .hrdata_in       (hrdata_in),
        .hready_in       (hready_in),
        .hresp_in        (hresp_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic err, input logic [1:0] cause);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cause = cause;
        exp_q.push_back(e);
    endtask

    // Cycle 0 is the handshake cycle; DATA starts at cycle 2 for aligned requests.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                           input int n_wait, input logic berr, input logic [31:0] rdata,
                           output int rsp_cyc, output logic saw_ns, output logic [31:0] a_haddr,
                           output logic a_hwrite, output logic [2:0] a_hsize,
                           output logic [31:0] d_hwdata, output int busy_lo);
        exp_t e;
        bit   done = 0;
        rsp_cyc  = -1;
        saw_ns   = 1'b0;
        a_haddr  = '0;
        a_hwrite = 1'b0;
        a_hsize  = '0;
        d_hwdata = '0;
        busy_lo  = 0;
        @(negedge clk_in);
        chk({name, ".req_ready"}, 32'(req_ready_out), 32'd1);
        req_valid_in    = 1'b1;
        req_write_in    = wr;
        req_addr_in     = addr;
        req_wdata_in    = wdata;
        req_size_in     = size;
        req_unsigned_in = uns;
        hready_in       = 1'b1;
        hresp_in        = 1'b0;
        hrdata_in       = rdata;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk_in);
            if (htrans_out === 2'b10) saw_ns = 1'b1;
            if (busy_out !== 1'b1) busy_lo++;
            if (c == 1) begin
                a_haddr  = haddr_out;
                a_hwrite = hwrite_out;
                a_hsize  = hsize_out;
            end
            if (c == 2) d_hwdata = hwdata_out;
            if (rsp_valid_out === 1'b1) begin
                rsp_cyc = c;
                done    = 1;
                if (exp_q.size() == 0) begin
                    chk({name, ".unexpected_rsp"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk({name, ".rdata"}, rsp_rdata_out, e.rdata);
                    chk({name, ".err"}, 32'(rsp_err_out), 32'(e.err));
                    chk({name, ".cause"}, 32'(rsp_cause_out), 32'(e.cause));
                    $display("[TB] %s: rsp at cycle %0d rdata=%h err=%0d cause=%0d",
                             name, c, rsp_rdata_out, rsp_err_out, rsp_cause_out);
                end
            end else begin
                hready_in = (c < 2) ? 1'b1 : ((c - 2) >= n_wait);
                hresp_in  = hready_in & berr;
            end
            if (!done) @(posedge clk_in);
        end
        if (!done) chk({name, ".rsp_seen"}, 32'd0, 32'd1);
        hready_in = 1'b1;
        hresp_in  = 1'b0;
        @(negedge clk_in);
        chk({name, ".pulse_one"}, 32'(rsp_valid_out), 32'd0);
        chk({name, ".idle_ready"}, 32'(req_ready_out), 32'd1);
    endtask

    int          rc;
    logic        ns;
    logic [31:0] ha;
    logic        hw;
    logic [2:0]  hs;
    logic [31:0] hd;
    int          bl;
    int          saw_rsp;

    initial begin
        rst_in          = 1'b1;
        req_valid_in    = 1'b0;
        req_write_in    = 1'b0;
        req_addr_in     = '0;
        req_wdata_in    = '0;
        req_size_in     = '0;
        req_unsigned_in = 1'b0;
        hrdata_in       = '0;
        hready_in       = 1'b1;
        hresp_in        = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst.htrans", 32'(htrans_out), 32'd0);
        chk("rst.haddr", haddr_out, 32'd0);
        chk("rst.hwdata", hwdata_out, 32'd0);
        chk("rst.ctrl", {25'd0, hwrite_out, hsize_out, rsp_valid_out, rsp_err_out, busy_out},
            32'd0);
        chk("rst.rsp", {rsp_rdata_out[29:0], rsp_cause_out}, 32'd0);
        chk("rst.ready", 32'(req_ready_out), 32'd1);

        // Word load, zero waits
        push_exp(32'h1234_5678, 1'b0, 2'b00);
        run_txn("ld_word", 1'b0, 32'h0000_1000, 32'd0, 2'b10, 1'b0, 0, 1'b0, 32'h1234_5678,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_word.cycle", 32'(rc), 32'd3);
        chk("ld_word.nonseq", 32'(ns), 32'd1);
        chk("ld_word.haddr", ha, 32'h0000_1000);
        chk("ld_word.busy", 32'(bl), 32'd0);

        // Signed byte load from lane 3
        push_exp(32'hFFFF_FF80, 1'b0, 2'b00);
        run_txn("ld_sbyte", 1'b0, 32'h0000_1003, 32'd0, 2'b00, 1'b0, 0, 1'b0, 32'h80FF_0000,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_sbyte.cycle", 32'(rc), 32'd3);

        // Unsigned half load from upper half
        push_exp(32'h0000_80FF, 1'b0, 2'b00);
        run_txn("ld_uhalf", 1'b0, 32'h0000_1002, 32'd0, 2'b01, 1'b1, 0, 1'b0, 32'h80FF_0000,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_uhalf.cycle", 32'(rc), 32'd3);

        // Signed half load from lower half
        push_exp(32'hFFFF_8001, 1'b0, 2'b00);
        run_txn("ld_shalf", 1'b0, 32'h0000_1000, 32'd0, 2'b01, 1'b0, 0, 1'b0, 32'h1234_8001,
                rc, ns, ha, hw, hs, hd, bl);

        // Byte store with lane replication
        push_exp(32'd0, 1'b0, 2'b00);
        run_txn("st_byte", 1'b1, 32'h0000_2001, 32'h0000_00AB, 2'b00, 1'b0, 0, 1'b0,
                32'hDEAD_BEEF, rc, ns, ha, hw, hs, hd, bl);
        chk("st_byte.cycle", 32'(rc), 32'd3);
        chk("st_byte.hwrite", 32'(hw), 32'd1);
        chk("st_byte.hsize", 32'(hs), 32'd0);
        chk("st_byte.haddr", ha, 32'h0000_2001);
        chk("st_byte.hwdata", hd, 32'hABAB_ABAB);

        // Half store replication
        push_exp(32'd0, 1'b0, 2'b00);
        run_txn("st_half", 1'b1, 32'h0000_2002, 32'h0000_C3D4, 2'b01, 1'b0, 0, 1'b0,
                32'd0, rc, ns, ha, hw, hs, hd, bl);
        chk("st_half.hsize", 32'(hs), 32'd1);
        chk("st_half.hwdata", hd, 32'hC3D4_C3D4);

        // Misaligned half: no bus transfer
        push_exp(32'd0, 1'b1, 2'b01);
        run_txn("mis_half", 1'b0, 32'h0000_1001, 32'd0, 2'b01, 1'b0, 0, 1'b0, 32'hFFFF_FFFF,
                rc, ns, ha, hw, hs, hd, bl);
        chk("mis_half.cycle", 32'(rc), 32'd1);
        chk("mis_half.nonseq", 32'(ns), 32'd0);

        // Illegal size is always misaligned
        push_exp(32'd0, 1'b1, 2'b01);
        run_txn("mis_size3", 1'b1, 32'h0000_3000, 32'd0, 2'b11, 1'b0, 0, 1'b0, 32'd0,
                rc, ns, ha, hw, hs, hd, bl);
        chk("mis_size3.cycle", 32'(rc), 32'd1);
        chk("mis_size3.nonseq", 32'(ns), 32'd0);

        // Misaligned word
        push_exp(32'd0, 1'b1, 2'b01);
        run_txn("mis_word", 1'b0, 32'h0000_3002, 32'd0, 2'b10, 1'b0, 0, 1'b0, 32'd0,
                rc, ns, ha, hw, hs, hd, bl);
        chk("mis_word.cycle", 32'(rc), 32'd1);

        // Word load with two wait states
        push_exp(32'hCAFE_F00D, 1'b0, 2'b00);
        run_txn("ld_wait2", 1'b0, 32'h0000_4000, 32'd0, 2'b10, 1'b0, 2, 1'b0, 32'hCAFE_F00D,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_wait2.cycle", 32'(rc), 32'd5);

        // Three waits then bus error
        push_exp(32'd0, 1'b1, 2'b10);
        run_txn("ld_buserr", 1'b0, 32'h0000_5000, 32'd0, 2'b10, 1'b0, 3, 1'b1, 32'h1111_2222,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_buserr.cycle", 32'(rc), 32'd6);

        // Ready held low: timeout after 16 wait cycles
        push_exp(32'd0, 1'b1, 2'b11);
        run_txn("ld_timeout", 1'b0, 32'h0000_6000, 32'd0, 2'b10, 1'b0, 100, 1'b0, 32'h3333_4444,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_timeout.cycle", 32'(rc), 32'd18);
        chk("ld_timeout.busy", 32'(bl), 32'd0);

        // Ready arrives on the limit cycle: completion wins
        push_exp(32'h5555_6666, 1'b0, 2'b00);
        run_txn("ld_limit", 1'b0, 32'h0000_7000, 32'd0, 2'b10, 1'b0, 15, 1'b0, 32'h5555_6666,
                rc, ns, ha, hw, hs, hd, bl);
        chk("ld_limit.cycle", 32'(rc), 32'd18);

        // Reset asserted during the DATA phase of a load
        @(negedge clk_in);
        req_valid_in    = 1'b1;
        req_write_in    = 1'b0;
        req_addr_in     = 32'h0000_8000;
        req_size_in     = 2'b10;
        req_unsigned_in = 1'b0;
        hready_in       = 1'b1;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        @(negedge clk_in);
        chk("rst_mid.addr_phase", 32'(htrans_out), 32'h2);
        @(negedge clk_in);
        chk("rst_mid.data_busy", 32'(busy_out), 32'd1);
        hready_in = 1'b0;
        rst_in    = 1'b1;
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        hready_in = 1'b1;
        @(negedge clk_in);
        chk("rst_mid.htrans", 32'(htrans_out), 32'd0);
        chk("rst_mid.ready", 32'(req_ready_out), 32'd1);
        chk("rst_mid.busy", 32'(busy_out), 32'd0);
        saw_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid_out === 1'b1) saw_rsp++;
            @(negedge clk_in);
        end
        chk("rst_mid.no_rsp", 32'(saw_rsp), 32'd0);
        $display("[TB] rst_mid: reset during DATA, rsp pulses seen=%0d", saw_rsp);

        chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
